// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: paces PC / IF-IF/ID updates against a variable-latency
// instruction memory, applying load-use stalls, ID redirects and fetch timeouts.
module fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic       load_use,
    input  logic       br_taken,
    input  logic       is_jr,
    input  logic       is_j,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       fetch_err,
    output logic       busy
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JR  = 2'b10;
    localparam logic [1:0] SRC_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    pend_src_q, pend_src_d;

    logic          redir_in;
    logic [1:0]    in_src;
    logic          redir;
    logic [1:0]    sel_src;
    logic          done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            pend_vld_q <= 1'b0;
            pend_src_q <= SRC_SEQ;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_src_q <= pend_src_d;
        end
    end

    always_comb begin
        redir_in = is_j | is_jr | br_taken;
        if (is_j)          in_src = SRC_J;
        else if (is_jr)    in_src = SRC_JR;
        else if (br_taken) in_src = SRC_BR;
        else               in_src = SRC_SEQ;
        redir   = redir_in | pend_vld_q;
        sel_src = pend_vld_q ? pend_src_q : in_src;
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pend_vld_d = pend_vld_q;
        pend_src_d = pend_src_q;
        done       = 1'b0;

        imem_req   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = SRC_SEQ;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        fetch_err  = 1'b0;
        busy       = 1'b1;

        case (state_q)
            ST_BOOT: begin
                ifid_flush = 1'b1;
                if (boot_cnt_q != BW'(BOOT_CYCLES))
                    boot_cnt_d = boot_cnt_q + BW'(1);
                if (boot_cnt_q >= BW'(BOOT_CYCLES - 1))
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b0;
                if (imem_ack) begin
                    done = 1'b1;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WW'(1);
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                // Only the first redirect seen while stalled is remembered.
                if (!pend_vld_q && redir_in) begin
                    pend_vld_d = 1'b1;
                    pend_src_d = in_src;
                end
                if (imem_ack) begin
                    done       = 1'b1;
                    state_d    = ST_FETCH;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WW'(MAX_WAIT)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ST_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // A load-use stall holds everything, including any pending redirect.
        if (done && !load_use) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            if (redir) begin
                pc_src     = sel_src;
                ifid_flush = 1'b1;
                pend_vld_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MAX_WAIT    = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req;
    logic       imem_ack = 1'b0;
    logic       load_use = 1'b0;
    logic       br_taken = 1'b0;
    logic       is_jr = 1'b0;
    logic       is_j = 1'b0;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ifid_write;
    logic       ifid_flush;
    logic       fetch_err;
    logic       busy;

    logic [7:0] obs_now;
    logic [7:0] obs_last;

    int n_checks = 0;
    int n_fail   = 0;

    // model: cycles since reset release, cycles the current request is outstanding,
    // pending redirect code (-1 none), timeout flag
    int m_cyc;
    int m_stall;
    int m_pend;
    bit m_err;

    fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .load_use   (load_use),
        .br_taken   (br_taken),
        .is_jr      (is_jr),
        .is_j       (is_j),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush),
        .fetch_err  (fetch_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign obs_now = {imem_req, pc_write, pc_src, ifid_write, ifid_flush, fetch_err, busy};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int redir_code(input bit br, input bit jr, input bit j);
        if (j)  return 3;
        if (jr) return 2;
        if (br) return 1;
        return -1;
    endfunction

    // expected {req, pc_write, pc_src, ifid_write, ifid_flush, fetch_err, busy}
    function automatic logic [7:0] model_out(input bit ack, input bit lu, input bit br,
                                             input bit jr, input bit j);
        logic [7:0] e;
        int code;
        if (m_cyc < BOOT_CYCLES) return 8'b0000_0101;
        if (m_err) return 8'b0000_0011;
        e = 8'b1000_0000;
        e[0] = (m_stall > 0);
        if (ack && !lu) begin
            e[6] = 1'b1;
            e[3] = 1'b1;
            code = (m_pend >= 0) ? m_pend : redir_code(br, jr, j);
            if (code >= 0) begin
                e[5:4] = 2'(code);
                e[2] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic model_step(input bit ack, input bit lu, input bit br,
                              input bit jr, input bit j);
        bit applied;
        int in_code;
        if (m_cyc < BOOT_CYCLES) begin
            m_cyc++;
            return;
        end
        if (m_err) return;
        in_code = redir_code(br, jr, j);
        applied = ack && !lu && (m_pend >= 0 || in_code >= 0);
        if (m_stall > 0 && m_pend < 0 && in_code >= 0) m_pend = in_code;
        if (applied) m_pend = -1;
        if (ack) m_stall = 0;
        else if (m_stall == MAX_WAIT) m_err = 1'b1;
        else m_stall++;
    endtask

    // called just after a rising edge; returns just after the next one
    task automatic cycle(input bit ack, input bit lu, input bit br,
                         input bit jr, input bit j);
        imem_ack = ack;
        load_use = lu;
        br_taken = br;
        is_jr    = jr;
        is_j     = j;
        @(negedge clk);
        obs_last = obs_now;
        check_eq("cycle_outputs", int'(obs_now), int'(model_out(ack, lu, br, jr, j)));
        model_step(ack, lu, br, jr, j);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_async_outputs", int'(obs_now), int'(8'b0000_0101));
        @(negedge clk);
        check_eq("rst_held_outputs", int'(obs_now), int'(8'b0000_0101));
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cyc   = 0;
        m_stall = 0;
        m_pend  = -1;
        m_err   = 1'b0;
    endtask

    initial begin
        int req_cnt, pw_cnt, busy_cnt, ack_pct;

        m_cyc = 0; m_stall = 0; m_pend = -1; m_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: boot then zero-wait fetch stream
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (i == 1) check_eq("t1_req_boot_last", int'(obs_last[7]), 0);
            if (i == 2) check_eq("t1_req_first", int'(obs_last[7]), 1);
            if (i >= 2) check_eq("t1_pc_write", int'(obs_last[6]), 1);
            if (i >= 2) check_eq("t1_pc_src", int'(obs_last[5:4]), 0);
        end

        // 2: ack after 3 stalled cycles
        req_cnt = 0; pw_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(i == 3, 0, 0, 0, 0);
            req_cnt  += int'(obs_last[7]);
            pw_cnt   += int'(obs_last[6]);
            busy_cnt += int'(obs_last[0]);
        end
        check_eq("t2_req_cycles", req_cnt, 4);
        check_eq("t2_pc_write_pulses", pw_cnt, 1);
        check_eq("t2_busy_cycles", busy_cnt, 3);

        // 3: jump, and jump beats branch
        cycle(1, 0, 0, 0, 1);
        check_eq("t3_j_src", int'(obs_last[5:4]), 3);
        check_eq("t3_j_flush", int'(obs_last[2]), 1);
        cycle(1, 0, 1, 0, 1);
        check_eq("t3_j_over_br", int'(obs_last[5:4]), 3);

        // 4: branch pulse during stall is remembered until the ack
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check_eq("t4_pend_src", int'(obs_last[5:4]), 1);
        check_eq("t4_pend_flush", int'(obs_last[2]), 1);

        // 5: load-use holds the redirect for a cycle
        cycle(1, 1, 1, 0, 0);
        check_eq("t5_lu_pc_write", int'(obs_last[6]), 0);
        check_eq("t5_lu_ifid_write", int'(obs_last[3]), 0);
        cycle(1, 0, 1, 0, 0);
        check_eq("t5_after_src", int'(obs_last[5:4]), 1);
        check_eq("t5_after_flush", int'(obs_last[2]), 1);

        // 6: timeout at the boundary, then reset recovery mid-stall
        for (int i = 0; i < 1 + MAX_WAIT; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (i == MAX_WAIT) check_eq("t6_last_wait_req", int'(obs_last[7]), 1);
        end
        cycle(1, 0, 0, 0, 0);
        check_eq("t6_fetch_err", int'(obs_last[1]), 1);
        check_eq("t6_err_req", int'(obs_last[7]), 0);
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        do_reset();
        cycle(1, 0, 0, 0, 0);
        check_eq("t6_late_ack_boot", int'(obs_last[6]), 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check_eq("t6_refetch", int'(obs_last[6]), 1);

        // randomized traffic with varying memory latency
        ack_pct = 100;
        for (int blk = 0; blk < 16; blk++) begin
            case (blk % 4)
                0: ack_pct = 100;
                1: ack_pct = 60;
                2: ack_pct = 25;
                default: ack_pct = 3;
            endcase
            if (m_err) do_reset();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 199) == 0) do_reset();
                cycle($urandom_range(0, 99) < ack_pct,
                      $urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 15);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
